// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: split req/addr_ok/data_ok handshake over a word array,
// in-order responses with fixed minimum latency and a bounded outstanding queue.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       rdata_q [DEPTH];
    logic [31:0]       rdata_d [DEPTH];
    logic [AGE_W-1:0]  age_q [DEPTH];
    logic [AGE_W-1:0]  age_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] widx;
    logic              resp_fire, accept, pop;
    logic              unused_bits;

    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    assign widx        = data_sram_addr[ADDR_W+1:2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign resp_fire         = (count_q != '0) && (age_q[head_q] == AGE_W'(LATENCY));
    assign data_sram_addr_ok = (count_q < CNT_W'(DEPTH)) || resp_fire;
    assign accept            = data_sram_req && data_sram_addr_ok && !reset;
    assign pop               = resp_fire && !reset;
    assign data_sram_data_ok = pop;
    assign data_sram_rdata   = pop ? rdata_q[head_q] : '0;

    // age == 0 marks an empty slot; live entries count up and park at LATENCY
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rdata_d = rdata_q;
        age_d   = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] != '0 && age_q[i] != AGE_W'(LATENCY))
                age_d[i] = age_q[i] + 1'b1;
        end
        if (pop) begin
            age_d[head_q] = '0;
            head_d        = ptr_inc(head_q);
        end
        // push after pop so a full queue with a same-cycle pop reuses the slot
        if (accept) begin
            age_d[tail_q]   = AGE_W'(1);
            rdata_d[tail_q] = data_sram_wr ? 32'h0 : mem[widx];
            tail_d          = ptr_inc(tail_q);
        end
        if (accept && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !accept)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) mem[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end
endmodule
